// File: rtl/instruction_encoder_loader.sv
// Re-encodes MIPS R/I/J instruction fields into 32-bit words and streams them
// into instruction memory at consecutive word addresses, one load session per start.
module instruction_encoder_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            fmt,
    input  logic [5:0]            opcode,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [4:0]            shamt,
    input  logic [5:0]            funct,
    input  logic [15:0]           immediate,
    input  logic [25:0]           address,
    input  logic                  last,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   count
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_e;

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = '1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic        accept;
    logic        legal;
    logic [31:0] enc;

    assign in_ready = (state_q == LOAD) && !start;
    assign busy     = (state_q == LOAD);
    assign accept   = in_valid && in_ready;
    assign legal    = (fmt != 2'b11);

    always_comb begin
        enc = 32'h0;
        unique case (fmt)
            2'b00:   enc = {opcode, rs, rt, rd, shamt, funct};
            2'b01:   enc = {opcode, rs, rt, immediate};
            2'b10:   enc = {opcode, address};
            default: enc = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
        if (start) begin
            state_d = LOAD;
            ptr_d   = BASE;
            count_d = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else if (accept) begin
            if (!legal) begin
                state_d = ERROR;
                err_d   = 1'b1;
            end else begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = enc;
                ptr_d   = ptr_q + 1'b1;
                count_d = count_q + 1'b1;
                // last at the top address is a clean finish, not an overflow
                if (last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (ptr_q == LAST_PTR) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= BASE;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign err        = err_q;
    assign count      = count_q;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Directed bench: table of encode vectors grouped into sessions, plus hand
// sequences for backpressure, illegal format, overflow and async reset.
module tb_instruction_encoder_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    fmt = '0;
    logic [5:0]    opcode = '0;
    logic [4:0]    rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]    funct = '0;
    logic [15:0]   immediate = '0;
    logic [25:0]   address = '0;
    logic          last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy, done, err;
    logic [AW:0]   count;

    instruction_encoder_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .immediate(immediate), .address(address), .last(last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  opcode;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] addr;
        logic        last;
        logic [31:0] exp;
    } vec_t;

    int   n_pass = 0;
    int   n_tot  = 0;
    vec_t vecs[6];

    function automatic vec_t mk(logic [1:0] f, logic [5:0] op, logic [4:0] a, logic [4:0] b,
                                logic [4:0] c, logic [4:0] s, logic [5:0] fn, logic [15:0] im,
                                logic [25:0] ad, logic l, logic [31:0] e);
        vec_t v;
        v.fmt = f; v.opcode = op; v.rs = a; v.rt = b; v.rd = c; v.shamt = s;
        v.funct = fn; v.imm = im; v.addr = ad; v.last = l; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        fmt = v.fmt; opcode = v.opcode; rs = v.rs; rt = v.rt; rd = v.rd;
        shamt = v.shamt; funct = v.funct; immediate = v.imm; address = v.addr; last = v.last;
    endtask

    task automatic garbage();
        fmt = 2'($urandom); opcode = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom);
        rd = 5'($urandom); shamt = 5'($urandom); funct = 6'($urandom);
        immediate = 16'($urandom); address = 26'($urandom); last = 1'($urandom);
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int   slot;
        vec_t v;

        vecs[0] = mk(2'b00, 6'h00, 5'd1,  5'd2, 5'd3,  5'd0,  6'h20, 16'h0000, 26'h0,       1'b1, 32'h00221820);
        vecs[1] = mk(2'b01, 6'h08, 5'd0,  5'd8, 5'd0,  5'd0,  6'h00, 16'h0005, 26'h0,       1'b0, 32'h20080005);
        vecs[2] = mk(2'b10, 6'h02, 5'd0,  5'd0, 5'd0,  5'd0,  6'h00, 16'h0000, 26'h0100000, 1'b1, 32'h08100000);
        vecs[3] = mk(2'b00, 6'h00, 5'd31, 5'd0, 5'd31, 5'd31, 6'h3f, 16'hffff, 26'h3ffffff, 1'b0, 32'h03e0ffff);
        vecs[4] = mk(2'b01, 6'h23, 5'd29, 5'd4, 5'd17, 5'd9,  6'h15, 16'h8000, 26'h1234567, 1'b1, 32'h8fa48000);
        vecs[5] = mk(2'b10, 6'h3f, 5'd7,  5'd7, 5'd7,  5'd7,  6'h07, 16'h1234, 26'h3ffffff, 1'b1, 32'hffffffff);

        // reset state
        #13;
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_count", 32'(count), 0);
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1;
        tick();
        chk("idle_no_write", 32'(imem_we), 0);
        chk("idle_ready", 32'(in_ready), 0);

        // table: each run of beats up to one flagged last is a session
        slot = 0;
        for (int i = 0; i < 6; i++) begin
            if (slot == 0) pulse_start();
            drive(vecs[i]);
            tick();
            chk($sformatf("v%0d_we", i), 32'(imem_we), 1);
            chk($sformatf("v%0d_addr", i), 32'(imem_addr), slot);
            chk($sformatf("v%0d_wdata", i), imem_wdata, vecs[i].exp);
            slot++;
            if (vecs[i].last) begin
                chk($sformatf("v%0d_done", i), 32'(done), 1);
                chk($sformatf("v%0d_count", i), 32'(count), slot);
                chk($sformatf("v%0d_ready", i), 32'(in_ready), 0);
                in_valid = 1'b0;
                tick();
                chk($sformatf("v%0d_we_drop", i), 32'(imem_we), 0);
                slot = 0;
            end
        end

        // backpressure with garbage fields between beats
        pulse_start();
        for (int b = 0; b < 3; b++) begin
            v = mk(2'b01, 6'(b + 1), 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'(b), 26'h0, 1'(b == 2), 32'h0);
            v.exp = {6'(b + 1), 10'h0, 16'(b)};
            drive(v);
            tick();
            chk($sformatf("bp%0d_we", b), 32'(imem_we), 1);
            chk($sformatf("bp%0d_addr", b), 32'(imem_addr), b);
            chk($sformatf("bp%0d_wdata", b), imem_wdata, v.exp);
            for (int g = 0; g < 2; g++) begin
                in_valid = 1'b0;
                garbage();
                tick();
                chk($sformatf("bp%0d_gap%0d", b, g), 32'(imem_we), 0);
            end
        end
        chk("bp_count", 32'(count), 3);
        chk("bp_done", 32'(done), 1);

        // illegal format on second beat
        pulse_start();
        drive(vecs[1]);
        tick();
        chk("ill_first_we", 32'(imem_we), 1);
        v = vecs[0];
        v.fmt = 2'b11;
        v.last = 1'b0;
        drive(v);
        tick();
        chk("ill_no_write", 32'(imem_we), 0);
        chk("ill_err", 32'(err), 1);
        chk("ill_ready", 32'(in_ready), 0);
        chk("ill_count", 32'(count), 1);
        tick();
        chk("ill_err_held", 32'(err), 1);
        pulse_start();
        chk("ill_err_clr", 32'(err), 0);
        chk("ill_busy", 32'(busy), 1);
        drive(vecs[0]);
        tick();
        chk("ill_restart_addr", 32'(imem_addr), 0);
        chk("ill_restart_we", 32'(imem_we), 1);

        // overflow: last only on beat 5, then last on beat 4
        for (int r = 0; r < 2; r++) begin
            pulse_start();
            for (int b = 0; b < 4; b++) begin
                v = vecs[3];
                v.last = (r == 1 && b == 3);
                drive(v);
                tick();
                chk($sformatf("ov%0d_addr%0d", r, b), {31'h0, imem_we} << 8 | 32'(imem_addr), 32'h100 | b);
            end
            chk($sformatf("ov%0d_err", r), 32'(err), (r == 0) ? 1 : 0);
            chk($sformatf("ov%0d_done", r), 32'(done), (r == 0) ? 0 : 1);
            chk($sformatf("ov%0d_ready", r), 32'(in_ready), 0);
            v.last = 1'b1;
            drive(v);
            tick();
            chk($sformatf("ov%0d_beat5_we", r), 32'(imem_we), 0);
            chk($sformatf("ov%0d_count", r), 32'(count), 4);
        end

        // async reset between edges mid-session
        pulse_start();
        v = vecs[3];
        drive(v);
        tick();
        chk("ar_pre_we", 32'(imem_we), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_we", 32'(imem_we), 0);
        chk("ar_wdata", imem_wdata, 0);
        chk("ar_count", 32'(count), 0);
        chk("ar_busy", 32'(busy), 0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("ar_ready", 32'(in_ready), 0);
        chk("ar_no_write", 32'(imem_we), 0);
        tick();
        chk("ar_still_idle", 32'(imem_we), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
